// File: rtl/mem_dump_reader_pkg.sv
// Shared constants and types for the data-memory subsystem and its dump reader.
// The reader's FSM encoding lives here so checkers and the top level can decode it.
package mem_dump_reader_pkg;

    localparam int DATA_W              = 32;
    localparam int ADDR_W              = 32;
    localparam int WORD_BYTES          = 4;
    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int COUNT_W             = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } dump_state_t;

    // Clamp a requested word count to the memory depth.
    function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W-1:0] cnt,
                                                     input int depth);
        if (int'(cnt) > depth) begin
            return COUNT_W'(depth);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a block of words out of the data memory over a valid/ready port.
// One memory read per word, then the word is held until the consumer takes it.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [COUNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0]   address_to_mem,
    output logic                mem_re,
    input  logic [DATA_W-1:0]   data_from_mem,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output dump_state_t         dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dump_state_t        state;
    dump_state_t        state_next;
    logic [IDX_W-1:0]   word_addr;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] start_count;
    logic               unused_addr_bits;

    assign start_count      = sat_count(word_count, DEPTH_WORDS);
    assign unused_addr_bits = ^{base_addr[ADDR_W-1:IDX_W+2], base_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake: a word transfers on any edge where out_valid && out_ready; out_valid
    // never drops and out_data never changes until that transfer has happened.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (start_count != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: state_next = S_SEND;
            S_SEND: begin
                if (out_ready) begin
                    state_next = (remaining > COUNT_W'(1)) ? S_READ : S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_addr <= '0;
            remaining <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_addr <= base_addr[IDX_W+1:2];
                        remaining <= start_count;
                    end
                end
                S_READ: out_data <= data_from_mem;
                S_SEND: begin
                    // The index is exactly IDX_W bits wide, so the increment wraps at the depth.
                    if (out_ready) begin
                        word_addr <= word_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_re         = (state == S_READ);
    assign address_to_mem = mem_re ? (ADDR_W'(word_addr) << 2) : '0;
    assign out_valid      = (state == S_SEND);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed-plus-random bench for mem_dump_reader against a word-list reference model.
module tb_mem_dump_reader;
    import mem_dump_reader_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [6:0]  word_count;
    logic [31:0] address_to_mem;
    logic        mem_re;
    logic [31:0] data_from_mem;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    dump_state_t dbg_state;

    logic [31:0] ram [DEPTH];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    mem_dump_reader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .address_to_mem (address_to_mem),
        .mem_re         (mem_re),
        .data_from_mem  (data_from_mem),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    assign data_from_mem = ram[address_to_mem[7:2]];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the word list a dump must produce, straight from base and count.
    task automatic build_expect(input logic [31:0] base, input logic [6:0] cnt);
        int eff;
        int first;
        int idx;
        eff   = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
        first = int'(base >> 2);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < eff; i++) begin
            idx = (first + i) % DEPTH;
            exp_addr_q.push_back(32'(idx * 4));
            exp_q.push_back(ram[idx]);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: five-cycle stall on word 2, 3: random ready + start pokes
    task automatic run_dump(input string tag, input logic [31:0] base, input logic [6:0] cnt,
                            input int mode);
        int cyc, n_hs, n_rd, n_done, first_valid, last_hs, done_cyc, stall_left, n_words;
        bit stalled_once, was_stalled, rdy;
        logic [31:0] held;
        build_expect(base, cnt);
        n_words = exp_q.size();
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        out_ready  = 1'b0;
        step();
        start = 1'b0;
        cyc = 1; n_hs = 0; n_rd = 0; n_done = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
        stall_left = 0; stalled_once = 0; was_stalled = 0; held = '0;
        while (done_cyc < 0 && cyc < 600) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (mem_re) begin
                n_rd++;
                if (exp_addr_q.size() > 0) check({tag, "_addr"}, address_to_mem, exp_addr_q.pop_front());
            end
            if (was_stalled) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"}, out_data, held);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            case (mode)
                0: rdy = 1'b1;
                2: begin
                    if (n_hs == 1 && out_valid && !stalled_once) begin
                        stall_left   = 5;
                        stalled_once = 1'b1;
                    end
                    rdy = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            if (mode == 3) begin
                start      = 1'($urandom_range(0, 1));
                base_addr  = $urandom;
                word_count = 7'($urandom);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                start    = 1'b0;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                n_hs++;
                last_hs = cyc;
                if (exp_q.size() > 0) check({tag, "_data"}, out_data, exp_q.pop_front());
            end
            was_stalled = out_valid && !rdy;
            held        = out_data;
            step();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, "_words"}, 32'(n_hs), 32'(n_words));
        check({tag, "_reads"}, 32'(n_rd), 32'(n_words));
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        if (n_words > 0) begin
            check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_hs + 1));
        end else begin
            check({tag, "_done_lat0"}, 32'(done_cyc), 32'd1);
            check({tag, "_no_valid"}, 32'(first_valid), 32'hFFFF_FFFF);
        end
        if (mode == 0 && n_words > 0) check({tag, "_first_valid"}, 32'(first_valid), 32'd2);
        if (mode == 2) check({tag, "_stalled"}, 32'(stalled_once), 32'd1);
    endtask

    initial begin
        int k;
        int hs;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        ram[4] = 32'hAAAA_0001;
        ram[5] = 32'hBBBB_0002;
        ram[6] = 32'hCCCC_0003;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", address_to_mem, 32'd0);
        reset = 1'b0;

        run_dump("abc", 32'h0000_0010, 7'd3, 0);
        run_dump("zero", 32'h0000_0020, 7'd0, 0);
        run_dump("wrap", 32'h0000_00F8, 7'd4, 0);
        run_dump("stall", $urandom, 7'd6, 2);
        run_dump("poke", $urandom, 7'd3, 3);

        // Reset while word 2 of 4 is being offered.
        out_ready = 1'b1; base_addr = 32'h0000_0040; word_count = 7'd4; start = 1'b1;
        step();
        start = 1'b0; k = 0; hs = 0;
        while (k < 50) begin
            if (out_valid) begin
                if (hs == 1) break;
                hs++;
            end
            step();
            k++;
        end
        check("rst_reach", 32'(k < 50), 32'd1);
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_re", 32'(mem_re), 32'd0);
        check("midrst_data", out_data, 32'd0);
        step();
        check("midrst_still_idle", 32'(busy), 32'd0);
        run_dump("after_rst", 32'h0000_0084, 7'd5, 1);

        run_dump("sat", $urandom, 7'd100, 1);
        for (int r = 0; r < 6; r++) begin
            run_dump("rand", $urandom, 7'($urandom_range(0, 70)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
